div32: RTL and testbench

Sequential unsigned 32-bit restoring divider: the inverse companion of the sequential shift-add multiplier in the ALU. It computes one quotient bit per clock through a separate control FSM and datapath. It returns a packed 64-bit `{remainder, quotient}` result, in the same layout convention as the multiplier's 64-bit product. The ALU selects it for the divide opcode and waits on `done`.

---
 rtl/div32_pkg.sv | 13 +
 rtl/div32_control.sv | 82 ++++++++
 rtl/div32_datapath.sv | 72 +++++++
 rtl/div32.sv | 52 +++++
 tb/tb_div32.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/div32_pkg.sv
// rtl/div32_pkg.sv - shared constants and state encoding for the sequential divider
package div32_pkg;

   localparam int WORD  = 32;
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ITER = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div32_control.sv
// rtl/div32_control.sv - divider FSM and iteration counter
module div32_control
   import div32_pkg::*;
#(
   parameter int WIDTH = WORD
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic b_zero,
   input  logic t_neg,
   output logic load,
   output logic dz_load,
   output logic shl,
   output logic sub_ok,
   output logic write,
   output logic last,
   output logic busy,
   output logic done
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (start) begin
               cnt_d = '0;
               if (b_zero) begin
                  state_d = DIV_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DIV_ITER;
                  busy_d  = 1'b1;
               end
            end
         end
         DIV_ITER: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
               state_d = DIV_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Datapath strobes decode straight from the current state
   assign load    = (state_q == DIV_IDLE) && start && !b_zero;
   assign dz_load = (state_q == DIV_IDLE) && start && b_zero;
   assign shl     = (state_q == DIV_ITER);
   assign sub_ok  = shl && !t_neg;
   assign last    = (cnt_q == CNT_W'(WIDTH - 1));
   assign write   = shl && last;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: rtl/div32_datapath.sv
// rtl/div32_datapath.sv - remainder/quotient shift register, trial subtractor and result register
module div32_datapath
   import div32_pkg::*;
#(
   parameter int WIDTH = WORD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               load,
   input  logic               dz_load,
   input  logic               shl,
   input  logic               sub_ok,
   input  logic               write,
   output logic               b_zero,
   output logic               t_neg,
   output logic [2*WIDTH-1:0] res,
   output logic               div_by_zero
);

   logic [2*WIDTH:0]   rq_q, rq_d, rq_sh, rq_it;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   logic               dz_q, dz_d;
   logic [WIDTH:0]     t;

   // Subtractor is one bit wider than the divisor so the shifted-out MSB is never lost
   assign rq_sh  = rq_q << 1;
   assign t      = rq_sh[2*WIDTH:WIDTH] - {1'b0, dvs_q};
   assign t_neg  = t[WIDTH];
   assign b_zero = (b == '0);
   assign rq_it  = sub_ok ? {t, rq_sh[WIDTH-1:1], 1'b1} : rq_sh;

   always_comb begin
      rq_d  = rq_q;
      dvs_d = dvs_q;
      res_d = res_q;
      dz_d  = dz_q;
      if (load) begin
         rq_d  = {{(WIDTH+1){1'b0}}, a};
         dvs_d = b;
      end else if (shl) begin
         rq_d = rq_it;
      end
      if (dz_load) begin
         res_d = {a, {WIDTH{1'b1}}};
         dz_d  = 1'b1;
      end else if (write) begin
         res_d = rq_it[2*WIDTH-1:0];
         dz_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rq_q  <= '0;
         dvs_q <= '0;
         res_q <= '0;
         dz_q  <= 1'b0;
      end else begin
         rq_q  <= rq_d;
         dvs_q <= dvs_d;
         res_q <= res_d;
         dz_q  <= dz_d;
      end
   end

   assign res         = res_q;
   assign div_by_zero = dz_q;

endmodule

// File: rtl/div32.sv
// rtl/div32.sv - sequential unsigned restoring divider returning {remainder, quotient}
module div32
   import div32_pkg::*;
#(
   parameter int WIDTH = WORD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] res
);

   logic load, dz_load, shl, sub_ok, write, last, b_zero, t_neg;

   div32_datapath #(.WIDTH(WIDTH)) dp (
      .clk         (clk),
      .rst         (rst),
      .a           (a),
      .b           (b),
      .load        (load),
      .dz_load     (dz_load),
      .shl         (shl),
      .sub_ok      (sub_ok),
      .write       (write),
      .b_zero      (b_zero),
      .t_neg       (t_neg),
      .res         (res),
      .div_by_zero (div_by_zero)
   );

   div32_control #(.WIDTH(WIDTH)) cu (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .b_zero  (b_zero),
      .t_neg   (t_neg),
      .load    (load),
      .dz_load (dz_load),
      .shl     (shl),
      .sub_ok  (sub_ok),
      .write   (write),
      .last    (last),
      .busy    (busy),
      .done    (done)
   );

endmodule

// File: tb/tb_div32.sv
// tb/tb_div32.sv - directed self-checking bench for div32
module tb_div32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_by_zero;
   logic [63:0] res;

   int n_checks = 0;
   int n_fail   = 0;

   div32 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .res         (res)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Accept one operation, then count busy cycles until done (bounded)
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dz, input int exp_lat);
      int n;
      int busy_cnt;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      busy_cnt = 0;
      while (!done && n < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         n++;
      end
      check_eq({tag, "_done_seen"}, 64'(done), 64'd1);
      check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
      check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
      check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check_eq({tag, "_quotient"}, 64'(res[31:0]), 64'(exp_q));
      check_eq({tag, "_remainder"}, 64'(res[63:32]), 64'(exp_r));
      check_eq({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
      @(posedge clk);
      #1;
      check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
      check_eq({tag, "_res_hold"}, res, {exp_r, exp_q});
   endtask

   initial begin
      int n;
      int done_cnt;
      int t_done[$];
      logic [63:0] res_seen;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_dz", 64'(div_by_zero), 64'd0);
      check_eq("rst_res", res, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
      run_op("full", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
      run_op("small", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32);
      run_op("dz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
      run_op("maxdiv", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32);
      run_op("bigrem", 32'hFFFF_FFFE, 32'h8000_0000, 32'd1, 32'h7FFF_FFFE, 1'b0, 32);

      // Reset in the middle of an operation
      @(negedge clk);
      a = 32'd12; b = 32'd6; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_busy", 64'(busy), 64'd0);
      check_eq("mid_rst_done", 64'(done), 64'd0);
      check_eq("mid_rst_dz", 64'(div_by_zero), 64'd0);
      check_eq("mid_rst_res", res, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("after_rst", 32'd12, 32'd6, 32'd2, 32'd0, 1'b0, 32);

      // Start pulse while busy must be ignored
      @(negedge clk);
      a = 32'd50; b = 32'd5; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      done_cnt = 0;
      res_seen = '0;
      for (int i = 1; i <= 45; i++) begin
         if (i == 5) begin
            a = 32'd9; b = 32'd3; start = 1'b1;
         end
         if (i == 6) start = 1'b0;
         @(posedge clk);
         #1;
         if (done) begin
            done_cnt++;
            res_seen = res;
         end
      end
      check_eq("busy_start_pulses", 64'(done_cnt), 64'd1);
      check_eq("busy_start_res", res_seen, {32'd0, 32'd10});

      // Continuous start: one completion every 34 cycles
      @(negedge clk);
      a = 32'd1000; b = 32'd33; start = 1'b1;
      n = 0;
      for (int i = 0; i < 120; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            t_done.push_back(i);
            check_eq("b2b_res", res, {32'd10, 32'd30});
         end
      end
      start = 1'b0;
      check_eq("b2b_pulses", 64'(t_done.size()), 64'd3);
      if (t_done.size() == 3) begin
         check_eq("b2b_first", 64'(t_done[0]), 64'd32);
         check_eq("b2b_gap1", 64'(t_done[1] - t_done[0]), 64'd34);
         check_eq("b2b_gap2", 64'(t_done[2] - t_done[1]), 64'd34);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
